// File: rtl/numbers_pkg.sv
// Shared definitions for the numbers field packer: symbol/field widths and FSM states.
package numbers_pkg;

  localparam int SYM_W = 2;
  localparam int A_W   = 4;
  localparam int B_W   = 2;

  // One state per expected symbol, plus a hold state while the frame waits for downstream.
  typedef enum logic [1:0] {
    S_A_HI,
    S_A_LO,
    S_B,
    S_HOLD
  } state_t;

endpackage

// File: rtl/numbers_field_packer_if.sv
// Symbol input and frame output handshakes of the numbers field packer.
interface numbers_field_packer_if;
  import numbers_pkg::*;

  logic             sym_valid;
  logic             sym_ready;
  logic [SYM_W-1:0] sym_data;
  logic             sym_sof;

  logic             out_valid;
  logic             out_ready;
  logic [A_W-1:0]   out_a;
  logic [B_W-1:0]   out_b;

  // Producer of symbols and consumer of frames.
  modport master (
    output sym_valid, sym_data, sym_sof, out_ready,
    input  sym_ready, out_valid, out_a, out_b
  );

  // The packer itself.
  modport slave (
    input  sym_valid, sym_data, sym_sof, out_ready,
    output sym_ready, out_valid, out_a, out_b
  );

endinterface

// File: rtl/numbers_sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module numbers_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Count increments until saturation; clear takes priority over inc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/numbers_field_packer.sv
// Packs three 2-bit symbols into a 4-bit field a and a 2-bit field b, holding the
// result until downstream accepts it. A start-of-frame inside a partial frame
// restarts the frame and is counted as an abort.
module numbers_field_packer
  import numbers_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  numbers_field_packer_if.slave bus,
  output logic [CNT_W-1:0]     abort_cnt
);

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             abort_inc;
  logic             load_frame;
  logic [SYM_W-1:0] a_hi;
  logic [SYM_W-1:0] a_lo;
  logic [A_W-1:0]   out_a_q;
  logic [B_W-1:0]   out_b_q;

  assign bus.sym_ready = (state != S_HOLD);
  assign bus.out_valid = (state == S_HOLD);
  assign bus.out_a     = out_a_q;
  assign bus.out_b     = out_b_q;
  assign accept        = bus.sym_valid && bus.sym_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_A_HI;
    end else begin
      state <= state_next;
    end
  end

  // Next state, abort detection and frame-complete strobe.
  always_comb begin
    state_next = state;
    abort_inc  = 1'b0;
    load_frame = 1'b0;
    case (state)
      S_A_HI: begin
        if (accept && bus.sym_sof) begin
          state_next = S_A_LO;
        end
      end
      S_A_LO: begin
        if (accept) begin
          if (bus.sym_sof) begin
            abort_inc = 1'b1;
          end else begin
            state_next = S_B;
          end
        end
      end
      S_B: begin
        if (accept) begin
          if (bus.sym_sof) begin
            abort_inc  = 1'b1;
            state_next = S_A_LO;
          end else begin
            load_frame = 1'b1;
            state_next = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          state_next = S_A_HI;
        end
      end
      default: state_next = S_A_HI;
    endcase
  end

  // Symbol capture; any accepted sof symbol starts a new a_hi.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_hi <= '0;
      a_lo <= '0;
    end else begin
      if (accept && bus.sym_sof) begin
        a_hi <= bus.sym_data;
      end
      if (accept && !bus.sym_sof && (state == S_A_LO)) begin
        a_lo <= bus.sym_data;
      end
    end
  end

  // Output fields change only when the frame completes, so they stay stable in hold and after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_a_q <= '0;
      out_b_q <= '0;
    end else if (load_frame) begin
      out_a_q <= {a_hi, a_lo};
      out_b_q <= bus.sym_data;
    end
  end

  numbers_sat_counter #(
    .WIDTH (CNT_W)
  ) u_abort_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (abort_inc),
    .clear (1'b0),
    .count (abort_cnt)
  );

endmodule

// File: tb/tb_numbers_field_packer.sv
// Directed self-checking bench for numbers_field_packer.
module tb_numbers_field_packer;

  logic       clk;
  logic       rst;
  logic [7:0] abort_cnt;
  int         testsRun;
  int         testsFailed;
  int         cycle;
  int         validCycle0;
  int         validCycle1;

  numbers_field_packer_if bus ();

  numbers_field_packer #(
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .abort_cnt (abort_cnt)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count used to measure frame spacing.
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Offers one symbol, waiting (bounded) for sym_ready, and returns 1 ns after the accepting edge.
  task automatic applyStimulus(input logic sof, input logic [1:0] data);
    int waitCycles;
    waitCycles = 0;
    bus.sym_valid = 1'b1;
    bus.sym_sof   = sof;
    bus.sym_data  = data;
    while (!bus.sym_ready && waitCycles < 20) begin
      @(posedge clk);
      #1;
      waitCycles++;
    end
    if (!bus.sym_ready) checkOutput("sym_ready_timeout", 32'(bus.sym_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.sym_valid = 1'b0;
  endtask

  task automatic checkFrame(input string tag, input logic [3:0] a, input logic [1:0] b);
    checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    checkOutput({tag, "_a"}, 32'(bus.out_a), 32'(a));
    checkOutput({tag, "_b"}, 32'(bus.out_b), 32'(b));
  endtask

  initial begin
    testsRun      = 0;
    testsFailed   = 0;
    cycle         = 0;
    rst           = 1'b1;
    bus.sym_valid = 1'b0;
    bus.sym_sof   = 1'b0;
    bus.sym_data  = 2'b00;
    bus.out_ready = 1'b1;

    // Reset state.
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_a", 32'(bus.out_a), 32'h0);
    checkOutput("rst_out_b", 32'(bus.out_b), 32'h0);
    checkOutput("rst_abort_cnt", 32'(abort_cnt), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_rst_sym_ready", 32'(bus.sym_ready), 32'd1);

    // Scenario 1: basic frame, taken immediately.
    applyStimulus(1'b1, 2'b10);
    applyStimulus(1'b0, 2'b11);
    applyStimulus(1'b0, 2'b01);
    checkFrame("s1", 4'hB, 2'b01);
    checkOutput("s1_hold_ready", 32'(bus.sym_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("s1_valid_drop", 32'(bus.out_valid), 32'd0);
    checkOutput("s1_a_kept", 32'(bus.out_a), 32'hB);
    checkOutput("s1_b_kept", 32'(bus.out_b), 32'h1);

    // Scenario 4: a non-sof symbol in S_A_HI is dropped without counting.
    applyStimulus(1'b0, 2'b11);
    applyStimulus(1'b1, 2'b00);
    applyStimulus(1'b0, 2'b01);
    applyStimulus(1'b0, 2'b11);
    checkFrame("s4", 4'h1, 2'b11);
    checkOutput("s4_abort_cnt", 32'(abort_cnt), 32'd0);
    @(posedge clk);
    #1;

    // Scenario 2: downstream stalls for 5 cycles while junk symbols are offered.
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 2'b10);
    applyStimulus(1'b0, 2'b11);
    applyStimulus(1'b0, 2'b01);
    bus.sym_valid = 1'b1;
    bus.sym_sof   = 1'b1;
    bus.sym_data  = 2'b00;
    for (int i = 0; i < 5; i++) begin
      checkFrame($sformatf("s2_stall%0d", i), 4'hB, 2'b01);
      checkOutput($sformatf("s2_stall%0d_ready", i), 32'(bus.sym_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    checkFrame("s2_before_take", 4'hB, 2'b01);
    bus.sym_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("s2_taken", 32'(bus.out_valid), 32'd0);
    checkOutput("s2_abort_cnt", 32'(abort_cnt), 32'd0);

    // Scenario 3: sof inside a partial frame aborts and restarts it.
    applyStimulus(1'b1, 2'b01);
    applyStimulus(1'b0, 2'b10);
    applyStimulus(1'b1, 2'b11);
    checkOutput("s3_abort_cnt", 32'(abort_cnt), 32'd1);
    applyStimulus(1'b0, 2'b00);
    applyStimulus(1'b0, 2'b10);
    checkFrame("s3", 4'hC, 2'b10);
    @(posedge clk);
    #1;

    // Back-to-back frames: one frame per 4 cycles.
    applyStimulus(1'b1, 2'b10);
    applyStimulus(1'b0, 2'b11);
    applyStimulus(1'b0, 2'b01);
    validCycle0 = cycle;
    checkFrame("tp0", 4'hB, 2'b01);
    applyStimulus(1'b1, 2'b01);
    applyStimulus(1'b0, 2'b00);
    applyStimulus(1'b0, 2'b11);
    validCycle1 = cycle;
    checkFrame("tp1", 4'h4, 2'b11);
    checkOutput("tp_spacing", 32'(validCycle1 - validCycle0), 32'd4);
    checkOutput("tp_abort_cnt", 32'(abort_cnt), 32'd1);
    @(posedge clk);
    #1;

    // Scenario 6: asynchronous reset after two symbols.
    applyStimulus(1'b1, 2'b11);
    applyStimulus(1'b0, 2'b10);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("s6_rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("s6_rst_abort_cnt", 32'(abort_cnt), 32'd0);
    checkOutput("s6_rst_out_a", 32'(bus.out_a), 32'h0);
    checkOutput("s6_rst_ready", 32'(bus.sym_ready), 32'd1);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 2'b01);
    applyStimulus(1'b0, 2'b11);
    applyStimulus(1'b0, 2'b10);
    checkFrame("s6", 4'h7, 2'b10);
    checkOutput("s6_abort_cnt", 32'(abort_cnt), 32'd0);
    @(posedge clk);
    #1;

    // Scenario 5: 300 aborts saturate the counter at 255.
    applyStimulus(1'b1, 2'b00);
    for (int i = 1; i <= 300; i++) begin
      applyStimulus(1'b1, 2'(i));
      if (i == 100) checkOutput("s5_cnt100", 32'(abort_cnt), 32'd100);
      if (i == 255) checkOutput("s5_cnt255", 32'(abort_cnt), 32'd255);
    end
    checkOutput("s5_cnt300", 32'(abort_cnt), 32'd255);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/numbers_field_packer.md
NUMBERS_FIELD_PACKER -- requirements
Module: numbers_field_packer

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set the width of the abort counter.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 sym_valid  input  1  SHALL mark sym_data/sym_sof as valid.
REQ-005 sym_ready  output  1  SHALL indicate that the block accepts a symbol this cycle.
REQ-006 sym_data  input  2  SHALL carry one 2-bit symbol.
REQ-007 sym_sof  input  1  SHALL flag the first symbol of a frame.
REQ-008 out_valid  output  1  SHALL mark out_a/out_b as a complete frame.
REQ-009 out_ready  input  1  SHALL indicate that downstream takes the frame.
REQ-010 out_a  output  4  SHALL carry the packed 4-bit field.
REQ-011 out_b  output  2  SHALL carry the packed 2-bit field.
REQ-012 abort_cnt  output  CNT_W  SHALL count aborted partial frames, saturating.

Function
REQ-013 A symbol SHALL be accepted only in a cycle where sym_valid and sym_ready are both 1.
REQ-014 A frame SHALL be three accepted symbols: s0 -> out_a[3:2], s1 -> out_a[1:0], s2 -> out_b[1:0].
REQ-015 FSM states SHALL be S_A_HI (reset state), S_A_LO, S_B and S_HOLD.
REQ-016 sym_ready SHALL be 1 in S_A_HI, S_A_LO and S_B, and 0 in S_HOLD.
REQ-017 In S_A_HI, an accepted symbol with sym_sof=1 SHALL be stored as a_hi, and the FSM SHALL go to S_A_LO.
REQ-018 In S_A_HI, an accepted symbol with sym_sof=0 SHALL be discarded, the FSM SHALL stay in S_A_HI, and abort_cnt SHALL be unchanged.
REQ-019 In S_A_LO, an accepted symbol with sym_sof=0 SHALL be stored as a_lo, and the FSM SHALL go to S_B.
REQ-020 In S_B, an accepted symbol with sym_sof=0 SHALL be stored as b, and the FSM SHALL go to S_HOLD.
REQ-021 In S_A_LO or S_B, an accepted symbol with sym_sof=1 SHALL:
- abort the partial frame;
- increment abort_cnt;
- be stored as the new a_hi;
- move the FSM to S_A_LO.
REQ-022 out_valid SHALL be 1 exactly while in S_HOLD, i.e. from the cycle after the third symbol is accepted (latency 1 cycle).
REQ-023 out_a/out_b SHALL update only on entry to S_HOLD.
REQ-024 out_a/out_b SHALL hold their values at all other times, including after the frame is taken.
REQ-025 In S_HOLD with out_ready=1, the frame SHALL be taken and the FSM SHALL go to S_A_HI next cycle; with out_ready=0 it SHALL remain in S_HOLD with outputs stable.
REQ-026 While out_valid=1, out_a/out_b/out_valid SHALL NOT change until out_ready=1.
REQ-027 abort_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-028 Sustained throughput SHALL be one frame per 4 cycles when sym_valid and out_ready are held at 1.
REQ-029 sym_data/sym_sof SHALL be ignored whenever the handshake does not complete.

Reset
REQ-030 Asserting rst SHALL immediately force:
- FSM to S_A_HI;
- out_valid=0;
- out_a=4'h0, out_b=2'b00;
- abort_cnt=0;
- internal a_hi/a_lo=0.
REQ-031 Reset mid-frame or in S_HOLD SHALL discard the partial or pending frame without incrementing abort_cnt.
REQ-032 After rst deasserts, sym_ready SHALL be 1 in the first clock edge cycle.

Structure
REQ-033 Shared package numbers_pkg SHALL hold:
- the FSM state enum;
- SYM_W=2;
- A_W=4;
- B_W=2.
REQ-034 The saturating counter SHALL be a sub-module numbers_sat_counter (parameter width, inputs inc/clear, output count).
REQ-035 out_a/out_b SHALL be directly compatible with the numbers_concat_repl a/b inputs.

Verification
REQ-036 Scenario 1: symbols {sof,2'b10}, 2'b11, 2'b01, out_ready=1 -> out_valid for 1 cycle, with out_a=4'hB and out_b=2'b01, 1 cycle after the third symbol.
REQ-037 Scenario 2: same frame with out_ready=0 for 5 cycles -> out_valid, out_a and out_b are stable for 5 cycles and sym_ready=0 throughout; frame taken on the 6th cycle.
REQ-038 Scenario 3: {sof,2'b01}, 2'b10, {sof,2'b11}, 2'b00, 2'b10 -> abort_cnt=1; delivered out_a=4'hC and out_b=2'b10.
REQ-039 Scenario 4: 2'b11 with sof=0 in S_A_HI, then a valid frame -> first symbol dropped, abort_cnt=0, frame delivered correctly.
REQ-040 Scenario 5: 300 sof-aborts with CNT_W=8 -> abort_cnt stops at 255.
REQ-041 Scenario 6: rst asserted after two symbols -> out_valid=0 and abort_cnt=0 immediately (asynchronously); the next full frame is delivered correctly.
